// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 target (MSB first, 8-bit frames) behind a 3-bit register bus (DATA/STATUS/CTRL).
// Latency: register reads return one clk after ren; SPI pins see SYNC flops plus one edge-detect flop.
// Backpressure: none; an RX byte arriving while rx_full is dropped (overrun) and an empty TX buffer sends DUMMY (underrun).
`timescale 1ns/1ps
module spi_slave #(
  parameter logic [7:0] DUMMY = 8'hFF,
  parameter int         SYNC  = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       ren,
  input  logic [2:0] raddr,
  output logic [7:0] rdata,
  input  logic       wen,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic       physs_n,
  input  logic       physck,
  input  logic       phymosi,
  output logic       phymiso,
  output logic       irq
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SYNC-1:0] r_ss_sync;
  logic [SYNC-1:0] r_sck_sync;
  logic [SYNC-1:0] r_mosi_sync;
  logic            r_ss_d;
  logic            r_sck_d;

  logic [0:0] r_state;
  logic [2:0] r_cnt;
  logic [6:0] r_rxsh;   // first seven bits of the byte being received
  logic [6:0] r_txsh;   // bits still to be driven after the one on phymiso
  logic       r_reload; // byte finished; next SCK fall loads a fresh TX byte

  logic [7:0] r_rx;
  logic       r_rx_full;
  logic [7:0] r_tx_buf;
  logic       r_tx_full;
  logic       r_ovr;
  logic       r_udr;
  logic [1:0] r_ctrl;

  logic       w_ss;
  logic       w_sck;
  logic       w_mosi;
  logic       w_en;
  logic       w_ss_fall;
  logic       w_ss_rise;
  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_start;
  logic       w_end;
  logic       w_active;
  logic       w_rise_evt;
  logic       w_fall_evt;
  logic       w_byte_done;
  logic       w_load;
  logic [7:0] w_load_val;
  logic [7:0] w_rx_byte;
  logic       w_busy;
  logic       w_rd_data;
  logic       w_wr_data;
  logic       w_wr_stat;
  logic       w_wr_ctrl;

  assign w_ss   = r_ss_sync[SYNC-1];
  assign w_sck  = r_sck_sync[SYNC-1];
  assign w_mosi = r_mosi_sync[SYNC-1];
  assign w_en   = r_ctrl[0];

  assign w_ss_fall  = r_ss_d & ~w_ss;
  assign w_ss_rise  = ~r_ss_d & w_ss;
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;

  // Clearing en mid-frame is treated exactly like the master releasing select.
  assign w_start     = w_en && (r_state == ST_IDLE) && w_ss_fall;
  assign w_end       = (r_state == ST_ACTIVE) && (!w_en || w_ss_rise);
  assign w_active    = w_en && (r_state == ST_ACTIVE) && !w_ss_rise;
  assign w_rise_evt  = w_active && w_sck_rise;
  assign w_fall_evt  = w_active && w_sck_fall;
  assign w_byte_done = w_rise_evt && (r_cnt == 3'd7);
  assign w_rx_byte   = {r_rxsh, w_mosi};

  // A load pulls the buffered byte if one is pending, otherwise DUMMY; the old buffer value is used even if written this cycle.
  assign w_load     = w_start || (w_fall_evt && r_reload);
  assign w_load_val = r_tx_full ? r_tx_buf : DUMMY;

  assign w_busy    = w_en & ~w_ss;
  assign w_rd_data = ren && (raddr == 3'd0);
  assign w_wr_data = wen && (waddr == 3'd0);
  assign w_wr_stat = wen && (waddr == 3'd1);
  assign w_wr_ctrl = wen && (waddr == 3'd2);

  // Bring the asynchronous SPI pins into clk and keep one previous sample for edge detection.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_ss_sync   <= '1;
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_ss_d      <= 1'b1;
      r_sck_d     <= 1'b0;
    end else begin
      r_ss_sync   <= {r_ss_sync[SYNC-2:0], physs_n};
      r_sck_sync  <= {r_sck_sync[SYNC-2:0], physck};
      r_mosi_sync <= {r_mosi_sync[SYNC-2:0], phymosi};
      r_ss_d      <= w_ss;
      r_sck_d     <= w_sck;
    end
  end

  // Frame sequencer: shift MOSI in on SCK rise, drive the next MISO bit on SCK fall.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 3'd0;
      r_rxsh   <= 7'd0;
      r_txsh   <= 7'd0;
      r_reload <= 1'b0;
      phymiso  <= 1'b1;
    end else if (!w_en || w_end) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 3'd0;
      r_reload <= 1'b0;
      phymiso  <= 1'b1;
    end else if (w_start) begin
      r_state  <= ST_ACTIVE;
      r_cnt    <= 3'd0;
      r_reload <= 1'b0;
      r_txsh   <= w_load_val[6:0];
      phymiso  <= w_load_val[7];
    end else if (w_rise_evt) begin
      r_rxsh <= w_rx_byte[6:0];
      r_cnt  <= r_cnt + 3'd1;
      if (r_cnt == 3'd7) begin
        r_reload <= 1'b1;
      end
    end else if (w_fall_evt) begin
      if (r_reload) begin
        r_txsh   <= w_load_val[6:0];
        phymiso  <= w_load_val[7];
        r_reload <= 1'b0;
      end else begin
        r_txsh  <= {r_txsh[5:0], 1'b0};
        phymiso <= r_txsh[6];
      end
    end
  end

  // RX byte and overrun: a read coinciding with completion frees the slot, so the new byte is kept.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_rx      <= 8'd0;
      r_rx_full <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      if (w_byte_done && (!r_rx_full || w_rd_data)) begin
        r_rx      <= w_rx_byte;
        r_rx_full <= 1'b1;
      end else if (w_rd_data) begin
        r_rx_full <= 1'b0;
      end
      if (w_byte_done && r_rx_full && !w_rd_data) begin
        r_ovr <= 1'b1;
      end else if (w_wr_stat && wdata[2]) begin
        r_ovr <= 1'b0;
      end
    end
  end

  // TX buffer and underrun: a write always wins over a same-cycle load clearing tx_full.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_tx_buf  <= 8'd0;
      r_tx_full <= 1'b0;
      r_udr     <= 1'b0;
    end else begin
      if (w_wr_data) begin
        r_tx_buf  <= wdata;
        r_tx_full <= 1'b1;
      end else if (w_load) begin
        r_tx_full <= 1'b0;
      end
      if (w_load && !r_tx_full) begin
        r_udr <= 1'b1;
      end else if (w_wr_stat && wdata[4]) begin
        r_udr <= 1'b0;
      end
    end
  end

  // Control register: bit0 enable, bit1 interrupt enable.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_ctrl <= 2'd0;
    end else if (w_wr_ctrl) begin
      r_ctrl <= wdata[1:0];
    end
  end

  // Registered read port; holds the last value while ren is low.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rdata <= 8'd0;
    end else if (ren) begin
      case (raddr)
        3'd0:    rdata <= r_rx;
        3'd1:    rdata <= {3'b000, r_udr, w_busy, r_ovr, r_tx_full, r_rx_full};
        3'd2:    rdata <= {6'd0, r_ctrl};
        default: rdata <= 8'd0;
      endcase
    end
  end

  // Level interrupt, one clk behind the flags.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      irq <= 1'b0;
    end else begin
      irq <= r_ctrl[1] & (r_rx_full | r_ovr);
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: register table, directed mode-0 frames and randomized frames for spi_slave.
// Expected values come from constants and a byte-level model (TX buffer, RX slot, flags).
// The SPI master runs at 8 clk per SCK phase and samples MISO at each SCK rise.
`timescale 1ns/1ps
module tb_spi_slave;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       ren;
  logic [2:0] raddr;
  logic [7:0] rdata;
  logic       wen;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic       physs_n;
  logic       physck;
  logic       phymosi;
  logic       phymiso;
  logic       irq;

  always #5 clk = ~clk;

  spi_slave #(.DUMMY(8'hFF), .SYNC(2)) dut (
    .clk(clk), .n_rst(n_rst),
    .ren(ren), .raddr(raddr), .rdata(rdata),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .physs_n(physs_n), .physck(physck), .phymosi(phymosi),
    .phymiso(phymiso), .irq(irq)
  );

  int n_err = 0;
  int n_chk = 0;

  // Byte-level reference model.
  logic [7:0] m_rx, m_tx_buf;
  logic       m_rx_full, m_tx_full, m_ovr, m_udr;
  logic [1:0] m_ctrl;

  logic [7:0] mo_bytes [0:3];
  logic [7:0] mi_bytes [0:3];
  logic [7:0] exp_miso [0:4];
  int         hk_wr_byte;
  int         hk_st_byte;
  logic [7:0] hk_wr_val;
  logic [7:0] hk_st_exp;

  typedef struct {
    bit         wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t vt [0:19];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_rx = 8'd0; m_tx_buf = 8'd0; m_rx_full = 1'b0; m_tx_full = 1'b0;
    m_ovr = 1'b0; m_udr = 1'b0; m_ctrl = 2'd0;
  endtask

  function automatic logic [7:0] m_expect(input logic [2:0] a);
    case (a)
      3'd0:    return m_rx;
      3'd1:    return {3'b000, m_udr, m_ctrl[0] & ~physs_n, m_ovr, m_tx_full, m_rx_full};
      3'd2:    return {6'd0, m_ctrl};
      default: return 8'd0;
    endcase
  endfunction

  task automatic m_take(output logic [7:0] v);
    if (m_tx_full) begin
      v = m_tx_buf;
      m_tx_full = 1'b0;
    end else begin
      v = 8'hFF;
      m_udr = 1'b1;
    end
  endtask

  task automatic m_store(input logic [7:0] b);
    if (m_rx_full) m_ovr = 1'b1;
    else begin
      m_rx = b;
      m_rx_full = 1'b1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wen = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    wen = 1'b0;
    case (a)
      3'd0: begin m_tx_buf = d; m_tx_full = 1'b1; end
      3'd1: begin
        if (d[2]) m_ovr = 1'b0;
        if (d[4]) m_udr = 1'b0;
      end
      3'd2: m_ctrl = d[1:0];
      default: ;
    endcase
  endtask

  task automatic check_read(input string name, input logic [2:0] a, input logic [7:0] exp);
    @(negedge clk);
    ren = 1'b1; raddr = a;
    @(negedge clk);
    ren = 1'b0;
    if (a == 3'd0) m_rx_full = 1'b0;
    chk(name, rdata, exp);
  endtask

  task automatic check_irq(input string name);
    @(negedge clk);
    @(negedge clk);
    chk(name, {7'd0, irq}, {7'd0, m_ctrl[1] & (m_rx_full | m_ovr)});
  endtask

  task automatic pulse(input logic v);
    phymosi = v;
    repeat (H) @(negedge clk);
    physck = 1'b1;
    repeat (H) @(negedge clk);
    physck = 1'b0;
  endtask

  // Mode-0 master for nbits bits from mo_bytes; model events follow the frame's timeline.
  task automatic spi_frame(input int nbits);
    int bi, b, left;
    logic en;
    logic [7:0] v;
    en = m_ctrl[0];
    physs_n = 1'b0;
    if (en) begin
      m_take(v);
      exp_miso[0] = v;
    end
    repeat (H) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      bi = k / 8;
      b  = k % 8;
      phymosi = mo_bytes[bi][7-b];
      repeat (H) @(negedge clk);
      physck = 1'b1;
      mi_bytes[bi][7-b] = phymiso;
      left = H;
      if (b == 7 && en) begin
        m_store(mo_bytes[bi]);
        chk("miso_byte", mi_bytes[bi], exp_miso[bi]);
      end
      if (b == 3 && bi == hk_wr_byte) begin
        bus_write(3'd0, hk_wr_val);
        left -= 2;
      end
      if (b == 7 && bi == hk_st_byte) begin
        repeat (4) @(negedge clk);
        check_read("status_in_frame", 3'd1, hk_st_exp);
        left -= 6;
      end
      repeat (left) @(negedge clk);
      physck = 1'b0;
      if (b == 7 && en) begin
        m_take(v);
        exp_miso[bi+1] = v;
      end
    end
    repeat (H) @(negedge clk);
    physs_n = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  initial begin
    n_rst = 1'b0; ren = 1'b0; raddr = 3'd0; wen = 1'b0; waddr = 3'd0; wdata = 8'd0;
    physs_n = 1'b1; physck = 1'b0; phymosi = 1'b0;
    hk_wr_byte = -1; hk_st_byte = -1; hk_wr_val = 8'd0; hk_st_exp = 8'd0;
    m_reset();
    repeat (4) @(negedge clk);
    n_rst = 1'b1;

    // Reset state and register map.
    chk("reset_miso", {7'd0, phymiso}, 8'h01);
    chk("reset_irq", {7'd0, irq}, 8'h00);
    for (int i = 0; i < 8; i++) vt[i] = '{1'b0, 3'(i), 8'h00, 8'h00};
    vt[8]  = '{1'b1, 3'd2, 8'hFF, 8'h00};
    vt[9]  = '{1'b0, 3'd2, 8'h00, 8'h03};
    vt[10] = '{1'b1, 3'd3, 8'hAA, 8'h00};
    vt[11] = '{1'b0, 3'd3, 8'h00, 8'h00};
    vt[12] = '{1'b1, 3'd7, 8'h55, 8'h00};
    vt[13] = '{1'b0, 3'd7, 8'h00, 8'h00};
    vt[14] = '{1'b1, 3'd0, 8'hA5, 8'h00};
    vt[15] = '{1'b0, 3'd1, 8'h00, 8'h02};
    vt[16] = '{1'b1, 3'd1, 8'hFF, 8'h00};
    vt[17] = '{1'b0, 3'd1, 8'h00, 8'h02};
    vt[18] = '{1'b1, 3'd2, 8'h00, 8'h00};
    vt[19] = '{1'b0, 3'd2, 8'h00, 8'h00};
    for (int i = 0; i < 20; i++) begin
      if (vt[i].wr) bus_write(vt[i].addr, vt[i].data);
      else check_read($sformatf("tbl%0d", i), vt[i].addr, vt[i].exp);
    end

    // Single byte with a pending TX byte.
    bus_write(3'd2, 8'h03);
    bus_write(3'd0, 8'hA5);
    mo_bytes[0] = 8'h3C;
    hk_st_byte = 0; hk_st_exp = 8'h09;
    spi_frame(8);
    hk_st_byte = -1;
    chk("t1_miso", mi_bytes[0], 8'hA5);
    check_irq("t1_irq_set");
    chk("t1_irq_one", {7'd0, irq}, 8'h01);
    check_read("t1_data", 3'd0, 8'h3C);
    check_irq("t1_irq_clr");

    // Two bytes with no TX data and no read in between.
    bus_write(3'd1, 8'h14);
    mo_bytes[0] = 8'h11; mo_bytes[1] = 8'h22;
    spi_frame(16);
    chk("t2_miso0", mi_bytes[0], 8'hFF);
    chk("t2_miso1", mi_bytes[1], 8'hFF);
    check_read("t2_status", 3'd1, 8'h15);
    bus_write(3'd1, 8'h14);
    check_read("t2_status_clr", 3'd1, 8'h01);
    check_read("t2_data", 3'd0, 8'h11);

    // Back-to-back bytes, second TX byte written during the first.
    bus_write(3'd0, 8'h55);
    mo_bytes[0] = 8'h9A; mo_bytes[1] = 8'h0F;
    hk_wr_byte = 0; hk_wr_val = 8'h66;
    spi_frame(16);
    hk_wr_byte = -1;
    chk("t3_miso0", mi_bytes[0], 8'h55);
    chk("t3_miso1", mi_bytes[1], 8'h66);
    check_read("t3_status", 3'd1, m_expect(3'd1));
    check_read("t3_data", 3'd0, 8'h9A);
    bus_write(3'd1, 8'h14);

    // Aborted partial byte followed by a full byte.
    mo_bytes[0] = 8'hF0;
    spi_frame(4);
    check_read("t4_status_partial", 3'd1, 8'h10);
    bus_write(3'd1, 8'h14);
    mo_bytes[0] = 8'hC3;
    spi_frame(8);
    check_read("t4_status", 3'd1, m_expect(3'd1));
    check_read("t4_data", 3'd0, 8'hC3);

    // Randomized traffic against the model.
    for (int it = 0; it < 25; it++) begin
      int n;
      if ($urandom_range(1, 0) == 1) bus_write(3'd0, 8'($urandom));
      if ($urandom_range(3, 0) == 0) bus_write(3'd1, 8'($urandom));
      if ($urandom_range(3, 0) == 0) bus_write(3'd2, {6'd0, 1'($urandom), 1'b1});
      n = $urandom_range(3, 1);
      for (int j = 0; j < 4; j++) mo_bytes[j] = 8'($urandom);
      hk_wr_byte = $urandom_range(3, 0);
      hk_wr_val = 8'($urandom);
      spi_frame(n * 8);
      hk_wr_byte = -1;
      check_read("rnd_status", 3'd1, m_expect(3'd1));
      check_irq("rnd_irq");
      if ($urandom_range(1, 0) == 1) check_read("rnd_data", 3'd0, m_expect(3'd0));
    end

    // Reset pulse in the middle of a byte.
    bus_write(3'd2, 8'h03);
    bus_write(3'd0, 8'h77);
    physs_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < 4; i++) pulse(1'b1);
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    m_reset();
    chk("t5_miso", {7'd0, phymiso}, 8'h01);
    check_read("t5_ctrl", 3'd2, 8'h00);
    check_read("t5_status", 3'd1, 8'h00);
    for (int i = 0; i < 8; i++) pulse(i[0]);
    check_read("t5_status_idle", 3'd1, 8'h00);
    bus_write(3'd2, 8'h03);
    for (int i = 0; i < 8; i++) pulse(i[0]);
    check_read("t5_status_en", 3'd1, 8'h08);
    chk("t5_miso_en", {7'd0, phymiso}, 8'h01);
    chk("t5_irq", {7'd0, irq}, 8'h00);
    physs_n = 1'b1;
    repeat (H) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (target) with the same 3-bit register-bus interface as the team's SPI initiator.
- Lets the core act as an SPI peripheral to an external master: receives MOSI bytes into an RX buffer and shifts TX-buffer bytes out on MISO.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames; all SPI pins are oversampled in the clk domain.

Parameters:
- DUMMY, 8'hFF, byte shifted out when no TX byte is pending at frame start.
- SYNC, 2, synchronizer depth for physs_n/physck/phymosi (minimum 2).

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset
- ren  in  1  register read strobe
- raddr  in  3  read address
- rdata  out  8  read data, registered
- wen  in  1  register write strobe
- waddr  in  3  write address
- wdata  in  8  write data
- physs_n  in  1  slave select from master, active-low, async
- physck  in  1  SPI clock from master, async
- phymosi  in  1  master-out data, async
- phymiso  out  1  slave-out data, registered
- irq  out  1  interrupt request, level

Behaviour:
- Reset: n_rst, synchronous, active-low; clock clk.
  - Values in reset: rdata=0, phymiso=1, irq=0; CTRL=0, all flags=0, bit count=0, shift registers=0.
  - Reset mid-frame abandons the frame; no partial byte is kept.
- Inputs pass through SYNC flops. Edges are detected on the synced signals by comparing with the previous sample.
- Master SCK high and low phases must each be >= 4 clk cycles.
- Register map, addresses 0-2; addresses 3-7 read 0 and ignore writes:
  - 0 DATA:
    - Read returns RX byte and clears rx_full.
    - Write loads TX buffer and sets tx_full. A write while tx_full overwrites the buffer.
  - 1 STATUS, read:
    - bit0 rx_full, bit1 tx_full, bit2 overrun, bit3 busy (synced ss asserted and enabled), bit4 underrun, bits7:5 = 0.
    - Writing 1 to bit2 or bit4 clears that flag; other bits are ignored.
  - 2 CTRL, R/W:
    - bit0 en, bit1 irqen, others read 0.
- Register reads: rdata is valid the cycle after ren; rdata holds its value when ren=0.
- irq = irqen & (rx_full | overrun), registered with 1-cycle latency.
- Frame sequencing, only when en=1:
  - IDLE -> ACTIVE on synced physs_n falling edge.
    - Load the shift-out register from the TX buffer and clear tx_full; if tx_full=0, load DUMMY and set underrun.
    - phymiso = bit7 on the next clk.
  - Synced SCK rising edge: shift the synced phymosi in at the LSB; cnt++.
  - Synced SCK falling edge: phymiso = next bit of the shift-out register.
  - On the 8th rising edge (cnt 7->0), the byte is complete:
    - rx_full=0: RX <= byte, rx_full=1.
    - rx_full=1: new byte discarded, RX unchanged, overrun=1.
    - The next falling edge reloads the shift-out register (TX or DUMMY, same rules as frame start) for back-to-back bytes.
  - physs_n rising edge -> IDLE:
    - cnt=0, partial byte discarded, phymiso=1.
    - No flag change, except that a TX buffer already reloaded stays consumed.
- en=0: state forced to IDLE, cnt=0, phymiso=1, SPI inputs ignored; registers stay accessible.
- Clearing en mid-frame behaves like physs_n deassertion.
- Simultaneous events:
  - DATA read in the same cycle as byte completion: read returns the old byte; the new byte is stored, rx_full stays 1, no overrun.
  - DATA write in the same cycle as a TX load: the load takes the old buffer value (or DUMMY if tx_full was 0); then buffer = wdata and tx_full=1.
  - STATUS write-1-clear in the same cycle as the flag being set: the set wins.
- No bit counter wraps beyond 8. A frame with more bytes continues indefinitely under the rules above.

Test Plan:
- Reset, then read all 8 addresses -> all read 0; phymiso=1, irq=0.
- CTRL=3, DATA<=8'hA5; master sends 8'h3C in mode 0 with SCK = 8 clk/phase -> MISO bits 1,0,1,0,0,1,0,1; STATUS=8'h09 during the frame; after the frame, DATA read=8'h3C, irq=1 then 0 after the read.
- No TX write; master sends 2 bytes 8'h11, 8'h22 without reading between them:
  - MISO sends 8'hFF twice; underrun=1.
  - RX=8'h11, overrun=1.
  - Write STATUS 8'h14 -> STATUS=8'h01.
- Back-to-back: write 8'h55, then write 8'h66 during byte 1 -> MISO sends 8'h55 then 8'h66; tx_full=0 at end.
- Deassert physs_n after 4 SCK rising edges, then a full byte 8'hC3 -> RX=8'hC3, no overrun; first partial bits discarded.
- n_rst low mid-byte for 1 cycle -> CTRL=0, flags 0, phymiso=1; SPI activity ignored until en is set again.
